// File: rtl/vga_axis_decoder.sv
// Per-axis VGA timing decoder: recovers glyph/pixel coordinates from an active flag and an
// active-low sync strobe, verifies period timing and reports lock. Define VGA_AXIS_DECODER_ERRCOUNT_EN for err_count/err_clear.
module vga_axis_decoder #(
    parameter int GLYPHS       = 80,
    parameter int PIXELS       = 10,
    parameter int FRONT_PORCH  = 210,
    parameter int BACK_PORCH   = 46,
    parameter int LOCK_PERIODS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      active_in,
    input  logic                      sync_in,
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
    input  logic                      err_clear,
    output logic [7:0]                err_count,
`endif
    output logic                      valid,
    output logic [$clog2(GLYPHS)-1:0] glyph,
    output logic [$clog2(PIXELS)-1:0] pixel,
    output logic                      locked,
    output logic                      carry,
    output logic                      error
);

    localparam int ACTIVE_LEN = GLYPHS * PIXELS;
    localparam int BLANK_LEN  = FRONT_PORCH + BACK_PORCH;
    localparam int GW = $clog2(GLYPHS);
    localparam int PW = $clog2(PIXELS);
    localparam int AW = $clog2(ACTIVE_LEN + 1);
    localparam int BW = $clog2(BLANK_LEN + 1);
    localparam int LW = $clog2(LOCK_PERIODS + 1);

    localparam logic [PW-1:0] PIXEL_LAST   = PW'(PIXELS - 1);
    localparam logic [AW-1:0] ACTIVE_LEN_C = AW'(ACTIVE_LEN);
    localparam logic [BW-1:0] BLANK_LEN_C  = BW'(BLANK_LEN);
    localparam logic [BW-1:0] FP_C         = BW'(FRONT_PORCH);
    localparam logic [LW-1:0] LOCK_C       = LW'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        HUNT,
        ACTIVE,
        BLANK
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [GW-1:0] glyph_q, glyph_d;
    logic [PW-1:0] pixel_q, pixel_d;
    logic [AW-1:0] act_cnt_q, act_cnt_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          sync_seen_q, sync_seen_d;
    logic [LW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic          carry_q, carry_d;
    logic          error_q, error_d;
    logic          prev_active_q;

    logic rise;
    logic sync_hit;
    logic sync_bad;
    logic sync_bad_first;

    assign rise           = active_in && !prev_active_q;
    assign sync_hit       = !sync_in && (blank_cnt_q == FP_C);
    assign sync_bad       = !sync_in && (blank_cnt_q != FP_C);
    // The falling sample is blank index 0, so sync there is legal only with a zero front porch.
    assign sync_bad_first = !sync_in && (FRONT_PORCH != 0);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        glyph_d     = glyph_q;
        pixel_d     = pixel_q;
        act_cnt_d   = act_cnt_q;
        blank_cnt_d = blank_cnt_q;
        sync_seen_d = sync_seen_q;
        good_d      = good_q;
        locked_d    = locked_q;
        carry_d     = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (rise) begin
                    state_d   = ACTIVE;
                    valid_d   = 1'b1;
                    glyph_d   = '0;
                    pixel_d   = '0;
                    act_cnt_d = AW'(1);
                end
            end

            ACTIVE: begin
                if (active_in) begin
                    if (act_cnt_q == ACTIVE_LEN_C) begin
                        error_d = 1'b1;
                        valid_d = 1'b0;
                        state_d = HUNT;
                    end else begin
                        act_cnt_d = act_cnt_q + 1'b1;
                        if (pixel_q == PIXEL_LAST) begin
                            pixel_d = '0;
                            glyph_d = glyph_q + 1'b1;
                        end else begin
                            pixel_d = pixel_q + 1'b1;
                        end
                    end
                end else begin
                    valid_d = 1'b0;
                    if (act_cnt_q != ACTIVE_LEN_C || sync_bad_first) begin
                        error_d = 1'b1;
                        state_d = HUNT;
                    end else begin
                        state_d     = BLANK;
                        blank_cnt_d = BW'(1);
                        sync_seen_d = !sync_in;
                    end
                end
            end

            BLANK: begin
                // BLANK is only ever entered and held on inactive samples, so active_in here is a rise.
                if (active_in) begin
                    state_d   = ACTIVE;
                    valid_d   = 1'b1;
                    glyph_d   = '0;
                    pixel_d   = '0;
                    act_cnt_d = AW'(1);
                    if (!sync_bad && blank_cnt_q == BLANK_LEN_C && (sync_seen_q || sync_hit)) begin
                        carry_d = 1'b1;
                        if (good_q != LOCK_C) good_d = good_q + 1'b1;
                        if (good_d == LOCK_C) locked_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sync_bad || blank_cnt_q >= BLANK_LEN_C) begin
                    error_d = 1'b1;
                    state_d = HUNT;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                    if (sync_hit) sync_seen_d = 1'b1;
                end
            end

            default: state_d = HUNT;
        endcase

        if (error_d) begin
            locked_d = 1'b0;
            good_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            valid_q       <= 1'b0;
            glyph_q       <= '0;
            pixel_q       <= '0;
            act_cnt_q     <= '0;
            blank_cnt_q   <= '0;
            sync_seen_q   <= 1'b0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            carry_q       <= 1'b0;
            error_q       <= 1'b0;
            prev_active_q <= 1'b0;
        end else if (ce) begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            glyph_q       <= glyph_d;
            pixel_q       <= pixel_d;
            act_cnt_q     <= act_cnt_d;
            blank_cnt_q   <= blank_cnt_d;
            sync_seen_q   <= sync_seen_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            carry_q       <= carry_d;
            error_q       <= error_d;
            prev_active_q <= active_in;
        end else begin
            carry_q <= 1'b0;
            error_q <= 1'b0;
        end
    end

    assign valid  = valid_q;
    assign glyph  = glyph_q;
    assign pixel  = pixel_q;
    assign locked = locked_q;
    assign carry  = carry_q;
    assign error  = error_q;

`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
    logic [7:0] err_count_q;

    // Clear wins over a coincident error; the clear ignores ce.
    always_ff @(posedge clk) begin
        if (reset || err_clear) begin
            err_count_q <= '0;
        end else if (ce && error_d && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_vga_axis_decoder.sv
// Self-checking bench for vga_axis_decoder: a period-level reference model plus a table of
// segment scenarios with hand-derived carry/error/lock expectations, randomized periods and resets.
`timescale 1ns/1ps
module tb_vga_axis_decoder;

    localparam int GLYPHS     = 80;
    localparam int PIXELS     = 10;
    localparam int FP         = 210;
    localparam int ACTIVE_LEN = GLYPHS * PIXELS;
    localparam int BLANK_LEN  = 256;
    localparam int LOCK       = 2;

    logic clk, reset, ce, active_in, sync_in;
    logic valid, locked, carry, error;
    logic [$clog2(GLYPHS)-1:0] glyph;
    logic [$clog2(PIXELS)-1:0] pixel;
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
    logic       err_clear;
    logic [7:0] err_count;
    int         m_errcnt;
`endif

    vga_axis_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .active_in (active_in),
        .sync_in   (sync_in),
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        .err_clear (err_clear),
        .err_count (err_count),
`endif
        .valid     (valid),
        .glyph     (glyph),
        .pixel     (pixel),
        .locked    (locked),
        .carry     (carry),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   act_len;
        int   blank_len;
        int   sync_idx;    // blank index of the sync pulse; == blank_len puts it on the next rise; -1 none
        int   exp_carry;   // carries seen during this segment's samples
        int   exp_error;   // errors seen during this segment's samples
        logic exp_locked;  // locked after the segment's last sample
    } seg_t;

    localparam int NROWS = 19;
    seg_t tbl [NROWS];

    int n_tests = 0;
    int n_fail  = 0;
    int gap     = 0;
    int obs_carry, obs_error;

    // Period-level model state.
    logic m_hunt;
    int   m_good;
    logic m_locked;
    int   m_outcome;          // verdict for the next rise: 0 resync from hunt, 1 good, 2 bad
    logic rise_sync_pending;
    logic e_valid;
    int   e_glyph, e_pixel;
    logic e_carry, e_error;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic ec, input logic ee);
        check("valid", int'(valid), int'(e_valid));
        check("locked", int'(locked), int'(m_locked));
        check("carry", int'(carry), int'(ec));
        check("error", int'(error), int'(ee));
        if (e_valid) begin
            check("glyph", int'(glyph), e_glyph);
            check("pixel", int'(pixel), e_pixel);
        end
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        check("err_count", int'(err_count), m_errcnt);
`endif
    endtask

    task automatic step(input logic a, input logic s);
        active_in = a;
        sync_in   = s;
        ce        = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        if (err_clear) m_errcnt = 0;
        else if (e_error && m_errcnt < 255) m_errcnt++;
`endif
        obs_carry += int'(carry);
        obs_error += int'(error);
        check_outputs(e_carry, e_error);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            obs_carry += int'(carry);
            obs_error += int'(error);
            check_outputs(1'b0, 1'b0);
        end
    endtask

    task automatic fail_hunt();
        m_hunt   = 1'b1;
        e_valid  = 1'b0;
        m_good   = 0;
        m_locked = 1'b0;
    endtask

    // One rise-to-rise segment: active run of length a_len, then b_len inactive samples.
    task automatic run_segment(input int a_len, input int b_len, input int s_idx);
        obs_carry = 0;
        obs_error = 0;
        for (int i = 0; i < a_len; i++) begin
            e_carry = 1'b0;
            e_error = 1'b0;
            if (i == 0) begin
                if (m_outcome == 1) begin
                    e_carry = 1'b1;
                    if (m_good < LOCK) m_good++;
                    if (m_good == LOCK) m_locked = 1'b1;
                end else if (m_outcome == 2) begin
                    e_error  = 1'b1;
                    m_good   = 0;
                    m_locked = 1'b0;
                end
                m_hunt  = 1'b0;
                e_valid = 1'b1;
                e_glyph = 0;
                e_pixel = 0;
                step(1'b1, !rise_sync_pending);
                rise_sync_pending = 1'b0;
            end else begin
                if (!m_hunt) begin
                    if (i < ACTIVE_LEN) begin
                        e_glyph = i / PIXELS;
                        e_pixel = i % PIXELS;
                    end else begin
                        e_error = 1'b1;
                        fail_hunt();
                    end
                end
                step(1'b1, 1'b1);
            end
        end
        for (int j = 0; j < b_len; j++) begin
            e_carry = 1'b0;
            e_error = 1'b0;
            if (!m_hunt) begin
                e_valid = 1'b0;
                if ((j == 0 && a_len != ACTIVE_LEN) || (j == s_idx && j != FP) || j >= BLANK_LEN) begin
                    e_error = 1'b1;
                    fail_hunt();
                end
            end
            step(1'b0, (j == s_idx) ? 1'b0 : 1'b1);
        end
        if (m_hunt) m_outcome = 0;
        else if (b_len == BLANK_LEN && s_idx == FP) m_outcome = 1;
        else m_outcome = 2;
        rise_sync_pending = (s_idx == b_len);
    endtask

    task automatic do_reset(input logic a);
        reset     = 1'b1;
        ce        = 1'b1;
        active_in = a;
        sync_in   = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ce        = 1'b0;
        active_in = 1'b0;
        m_hunt = 1'b1; m_good = 0; m_locked = 1'b0; m_outcome = 0;
        e_valid = 1'b0; e_carry = 1'b0; e_error = 1'b0; rise_sync_pending = 1'b0;
        check("rst_valid", int'(valid), 0);
        check("rst_glyph", int'(glyph), 0);
        check("rst_pixel", int'(pixel), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_carry", int'(carry), 0);
        check("rst_error", int'(error), 0);
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        m_errcnt = 0;
        check("rst_err_count", int'(err_count), 0);
`endif
    endtask

    task automatic run_row(input int r);
        run_segment(tbl[r].act_len, tbl[r].blank_len, tbl[r].sync_idx);
        check($sformatf("row%0d_carries", r), obs_carry, tbl[r].exp_carry);
        check($sformatf("row%0d_errors", r), obs_error, tbl[r].exp_error);
        check($sformatf("row%0d_locked", r), int'(locked), int'(tbl[r].exp_locked));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{800, 256, 210, 0, 0, 1'b0};  // first rise from hunt
        tbl[1]  = '{800, 256, 210, 1, 0, 1'b0};
        tbl[2]  = '{800, 256, 210, 1, 0, 1'b1};  // second carry locks
        tbl[3]  = '{799, 256, 210, 1, 1, 1'b0};  // short active: error at the fall
        tbl[4]  = '{800, 256, 210, 0, 0, 1'b0};
        tbl[5]  = '{800, 256, 210, 1, 0, 1'b0};
        tbl[6]  = '{800, 256, 209, 1, 1, 1'b0};  // relocks at the rise, sync early
        tbl[7]  = '{800, 300, 210, 0, 1, 1'b0};  // blank overrun
        tbl[8]  = '{800, 256, 210, 0, 0, 1'b0};
        tbl[9]  = '{800, 256, 210, 1, 0, 1'b0};
        tbl[10] = '{801, 256, 210, 1, 1, 1'b0};  // active overrun
        tbl[11] = '{800, 255, 210, 0, 0, 1'b0};  // short blank: flagged at the next rise
        tbl[12] = '{800, 256, 210, 0, 1, 1'b0};
        tbl[13] = '{800, 256, 256, 1, 0, 1'b0};  // sync moved onto the next rise
        tbl[14] = '{800, 256, 210, 0, 1, 1'b0};  // rise + stray sync: one error
        tbl[15] = '{800, 256, 210, 1, 0, 1'b0};
        tbl[16] = '{800, 256, 210, 1, 0, 1'b1};
        tbl[17] = '{800, 256,  -1, 1, 0, 1'b1};  // missing sync
        tbl[18] = '{800, 256, 210, 0, 1, 1'b0};

        reset = 1'b0; ce = 1'b0; active_in = 1'b0; sync_in = 1'b1;
`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        err_clear = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset(1'b0);
        for (int r = 0; r < NROWS; r++) run_row(r);

        // Same compliant periods with ce high on every third clock.
        do_reset(1'b0);
        gap = 2;
        for (int r = 0; r < 3; r++) run_row(r);
        gap = 0;

        for (int k = 0; k < 10; k++) begin
            int a_len, b_len, s_idx, pick;
            pick  = int'($urandom_range(0, 9));
            a_len = (pick < 7) ? ACTIVE_LEN : int'($urandom_range(795, 805));
            pick  = int'($urandom_range(0, 9));
            b_len = (pick < 7) ? BLANK_LEN : int'($urandom_range(250, 262));
            pick  = int'($urandom_range(0, 9));
            if (pick < 6) s_idx = FP;
            else if (pick < 8) s_idx = int'($urandom_range(0, b_len));
            else s_idx = -1;
            gap = int'($urandom_range(0, 1));
            run_segment(a_len, b_len, s_idx);
        end
        gap = 0;

        // Reset in the middle of an active region while locked.
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) run_row(r);
        run_segment(401, 0, -1);
        check("mid_glyph", int'(glyph), 40);
        do_reset(1'b1);
        run_segment(ACTIVE_LEN, BLANK_LEN, FP);
        check("post_rst_carries", obs_carry, 0);
        check("post_rst_errors", obs_error, 0);

`ifdef VGA_AXIS_DECODER_ERRCOUNT_EN
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) run_segment(799, 256, FP);
        check("errcnt_three", int'(err_count), 3);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        m_errcnt  = 0;
        check("errcnt_clear", int'(err_count), 0);
        run_segment(800, 0, -1);
        e_carry = 1'b0;
        e_error = 1'b1;
        fail_hunt();
        err_clear = 1'b1;
        step(1'b1, 1'b1);
        err_clear = 1'b0;
        check("errcnt_clear_wins", int'(err_count), 0);
        for (int r = 0; r < 260; r++) run_segment(1, 1, -1);
        check("errcnt_saturate", int'(err_count), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
